wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Write-back end of the MEM/WB interface.
- Consumes the MEM/WB register outputs and selects the write-back value (load data or ALU result).
- Commits that value into a 32-entry architectural integer register file and serves the ID stage's two read ports.
- Provides write-through bypass so a same-cycle write is visible to ID reads without a stall.

Parameters:
- XLEN, 64, data width of registers and write-back paths.
- REG_ADDR_W, 5, register index width; register count is 2**REG_ADDR_W.
- BYPASS_EN, 1, 1 = same-cycle write-to-read bypass on rs1/rs2; 0 = reads return stored array contents only.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_data_in  in  XLEN  load data from MEM/WB.
- alu_result_in  in  XLEN  ALU result from MEM/WB.
- rd_in  in  REG_ADDR_W  destination register index.
- RegWrite_in  in  1  write enable from MEM/WB.
- MemtoReg_in  in  1  1 = write mem_data_in, 0 = write alu_result_in.
- rs1_addr  in  REG_ADDR_W  read port 1 index (ID stage).
- rs2_addr  in  REG_ADDR_W  read port 2 index.
- rs1_data  out  XLEN  read port 1 data (combinational).
- rs2_data  out  XLEN  read port 2 data (combinational).
- wb_data  out  XLEN  selected write-back value (combinational), for EX forwarding.
- wb_we  out  1  qualified write enable = RegWrite_in and rd_in != 0.

Behaviour:
- Write-back select:
  - wb_data = MemtoReg_in ? mem_data_in : alu_result_in.
  - wb_data is pure combinational; it does not depend on RegWrite_in.
- Write:
  - On posedge clk, if wb_we is high, regs[rd_in] <= wb_data.
  - Exactly one write per cycle; no other register changes.
- x0:
  - Writes to index 0 are dropped; wb_we stays 0 even when RegWrite_in = 1.
  - Reads of index 0 always return 0, both with and without bypass.
- Read (latency 0, combinational):
  - rsN_data = 0 if rsN_addr == 0.
  - Else, if BYPASS_EN and wb_we and rsN_addr == rd_in: rsN_data = wb_data.
  - Else rsN_data = regs[rsN_addr].
- Both ports may address the same register; both return identical data.
- Write and bypass apply to any non-zero rd, including the last index.
- Reset:
  - Asserting reset asynchronously clears all registers to 0 (and the optional counter); this holds even if a write is pending in the same cycle.
  - While reset is high, no writes occur. Read outputs remain combinational: with BYPASS_EN, a matching wb_we still bypasses wb_data; otherwise reads return 0.
  - After reset deasserts, the first rising edge with wb_we performs a normal write.
- Outputs after reset:
  - rs1_data/rs2_data = 0 unless bypassed.
  - wb_data and wb_we follow their inputs.
- Unknown/X on RegWrite_in is not tolerated; the bench asserts it is 0/1 after reset.

Optional Feature:
- Macro WB_RETIRE_COUNT_EN.
- Defined:
  - Adds output retire_count (64 bits), reset to 0 asynchronously.
  - Increments by 1 on every rising edge where wb_we = 1.
  - Wraps from all-ones to 0 with no flag.
  - Writes attempted to x0 are not counted.
- Undefined: the port and the counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared package riscv_pkg:
  - XLEN = 64, REG_ADDR_W = 5, NUM_REGS = 32.
  - REG_ZERO = 5'd0.
  - Typedef for the register index and the XLEN data word.
- One natural sub-module, wb_select: the combinational MemtoReg mux plus wb_we qualification.
- The register array, bypass logic and optional counter stay in wb_regfile.

Test Plan:
1. Reset, then read all 32 indices on both ports → every read = 0; wb_we = 0 with RegWrite_in = 0.
2. RegWrite=1, MemtoReg=0, rd=5, alu=0x0000_0000_DEAD_BEEF, one clock → rs1_addr=5 reads 0xDEADBEEF next cycle; rs2_addr=6 still reads 0.
3. RegWrite=1, MemtoReg=1, rd=7, mem=0xFFFF_FFFF_FFFF_FFFF, rs1=rs2=7 in the same cycle (BYPASS_EN=1) → both ports read all-ones before the edge. Repeat with BYPASS_EN=0 → both ports read the old value (0) until after the edge.
4. RegWrite=1, rd=0, alu=0x1234, clock → wb_we=0, x0 reads 0; with WB_RETIRE_COUNT_EN, retire_count unchanged.
5. Write x31=0xA5A5 and x1=0x5A5A, then assert reset asynchronously mid-cycle (between edges) → x1 and x31 read 0 immediately; retire_count = 0. Deassert reset and write x1=3 → reads 3.
6. WB_RETIRE_COUNT_EN: force the counter to 0xFFFF_FFFF_FFFF_FFFE, issue 3 valid writes → counts 0x...FFFF, 0, 1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V integer datapath constants and types used by the
// write-back stage and register file.
package riscv_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]       xlen_t;

endpackage : riscv_pkg

// File: rtl/wb_select.sv
// Write-back value selection for the MEM/WB boundary: picks load data or
// ALU result and qualifies the write enable so x0 is never written.
module wb_select #(
  parameter int XLEN       = riscv_pkg::XLEN,
  parameter int REG_ADDR_W = riscv_pkg::REG_ADDR_W
) (
  input  logic [XLEN-1:0]       i_mem_data,
  input  logic [XLEN-1:0]       i_alu_result,
  input  logic [REG_ADDR_W-1:0] i_rd,
  input  logic                  i_reg_write,
  input  logic                  i_mem_to_reg,
  output logic [XLEN-1:0]       o_wb_data,
  output logic                  o_wb_we
);

  // Select the value to commit; independent of the write enable so EX
  // forwarding always sees the live MEM/WB value.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    o_wb_data = i_alu_result;
    if (i_mem_to_reg) o_wb_data = i_mem_data;
  end

  // A write to x0 is architecturally a no-op, so drop it here once.
  assign o_wb_we = i_reg_write && (i_rd != '0);

endmodule : wb_select

// File: rtl/wb_regfile.sv
// Write-back stage register file: commits the MEM/WB result into the
// 32-entry integer register file and serves two combinational ID read
// ports with optional same-cycle write-through bypass.
// Optional build feature: define WB_RETIRE_COUNT_EN to add a 64-bit
// retire_count output counting every committed register write.
module wb_regfile #(
  parameter int XLEN       = riscv_pkg::XLEN,
  parameter int REG_ADDR_W = riscv_pkg::REG_ADDR_W,
  parameter bit BYPASS_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [XLEN-1:0]       mem_data_in,
  input  logic [XLEN-1:0]       alu_result_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic                  RegWrite_in,
  input  logic                  MemtoReg_in,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data,
  output logic [XLEN-1:0]       wb_data,
  output logic                  wb_we
`ifdef WB_RETIRE_COUNT_EN
  ,
  output logic [63:0]           retire_count
`endif
);

  localparam int NUM_REGS = 2 ** REG_ADDR_W;

  logic [XLEN-1:0] r_regs [NUM_REGS];
  logic [XLEN-1:0] w_wb_data;
  logic            w_wb_we;

  wb_select #(
    .XLEN       (XLEN),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_wb_select (
    .i_mem_data   (mem_data_in),
    .i_alu_result (alu_result_in),
    .i_rd         (rd_in),
    .i_reg_write  (RegWrite_in),
    .i_mem_to_reg (MemtoReg_in),
    .o_wb_data    (w_wb_data),
    .o_wb_we      (w_wb_we)
  );

  assign wb_data = w_wb_data;
  assign wb_we   = w_wb_we;

  // Commit the selected write-back value; reset clears every entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the array is reset in full because software relies on all
      // registers reading 0 after reset; this keeps it in flops, not RAM.
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wb_we) begin
      // NOTE: state is updated with <= so every flop samples pre-edge
      // values regardless of statement order.
      r_regs[rd_in] <= w_wb_data;
    end
  end

  // One read port: x0 is hard-wired, a matching in-flight write wins when
  // bypass is built in, otherwise the stored entry is returned.
  function automatic logic [XLEN-1:0] read_port(input logic [REG_ADDR_W-1:0] addr);
    logic [XLEN-1:0] data;
    data = r_regs[addr];
    if (addr == '0) data = '0;
    else if (BYPASS_EN && w_wb_we && (addr == rd_in)) data = w_wb_data;
    return data;
  endfunction

  // Combinational read for ID operand rs1.
  always_comb begin
    rs1_data = read_port(rs1_addr);
  end

  // Combinational read for ID operand rs2.
  always_comb begin
    rs2_data = read_port(rs2_addr);
  end

`ifdef WB_RETIRE_COUNT_EN
  logic [63:0] r_retire_count;

  // Count committed writes; x0 writes never qualify, wrap is silent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_retire_count <= '0;
    else if (w_wb_we) r_retire_count <= r_retire_count + 64'd1;
  end

  assign retire_count = r_retire_count;
`endif

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile. Two instances share the
// stimulus: dut (bypass enabled) and dut_nb (bypass disabled).
// Counter checks are compiled in when WB_RETIRE_COUNT_EN is defined.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] mem_data_in, alu_result_in;
  logic [4:0]  rd_in, rs1_addr, rs2_addr;
  logic        RegWrite_in, MemtoReg_in;

  logic [63:0] d_rs1, d_rs2, d_wb_data;
  logic        d_wb_we;
  logic [63:0] n_rs1, n_rs2, n_wb_data;
  logic        n_wb_we;
`ifdef WB_RETIRE_COUNT_EN
  logic [63:0] d_cnt, n_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_regfile #(.BYPASS_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .mem_data_in(mem_data_in), .alu_result_in(alu_result_in),
    .rd_in(rd_in), .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(d_rs1), .rs2_data(d_rs2),
    .wb_data(d_wb_data), .wb_we(d_wb_we)
`ifdef WB_RETIRE_COUNT_EN
    , .retire_count(d_cnt)
`endif
  );

  wb_regfile #(.BYPASS_EN(1'b0)) dut_nb (
    .clk(clk), .reset(reset),
    .mem_data_in(mem_data_in), .alu_result_in(alu_result_in),
    .rd_in(rd_in), .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(n_rs1), .rs2_data(n_rs2),
    .wb_data(n_wb_data), .wb_we(n_wb_we)
`ifdef WB_RETIRE_COUNT_EN
    , .retire_count(n_cnt)
`endif
  );

  // RegWrite_in must never be unknown once out of reset.
  always @(posedge clk) begin
    if (reset === 1'b0) assert (!$isunknown(RegWrite_in)) else $error("RegWrite_in unknown");
  end

  // Runaway guard.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1);
  end

  // Register write of an ALU value, committed by the next rising edge.
  task automatic write_reg(input logic [4:0] rd, input logic [63:0] data);
    @(negedge clk);
    RegWrite_in = 1'b1; MemtoReg_in = 1'b0; rd_in = rd;
    alu_result_in = data; mem_data_in = ~data;
    @(posedge clk); #1;
    RegWrite_in = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    RegWrite_in = 1'b0; MemtoReg_in = 1'b0; rd_in = '0;
    mem_data_in = '0; alu_result_in = '0; rs1_addr = '0; rs2_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(31 - i); #1;
      checks++;
      if (d_rs1 !== 64'd0 || d_rs2 !== 64'd0 || n_rs1 !== 64'd0 || n_rs2 !== 64'd0) begin
        errors++;
        $display("FAIL reset_read idx=%0d got=%h/%h/%h/%h exp=0", i, d_rs1, d_rs2, n_rs1, n_rs2);
      end
    end
    checks++;
    if (d_wb_we !== 1'b0) begin errors++; $display("FAIL reset_wb_we got=%b exp=0", d_wb_we); end
`ifdef WB_RETIRE_COUNT_EN
    checks++;
    if (d_cnt !== 64'd0) begin errors++; $display("FAIL reset_count got=%h exp=0", d_cnt); end
`endif
  endtask

  task automatic test_write;
    @(negedge clk);
    RegWrite_in = 1'b1; MemtoReg_in = 1'b0; rd_in = 5'd5;
    alu_result_in = 64'h0000_0000_DEAD_BEEF; mem_data_in = 64'h1111_2222_3333_4444;
    rs1_addr = 5'd5; rs2_addr = 5'd6; #1;
    checks++;
    if (d_wb_data !== 64'h0000_0000_DEAD_BEEF) begin errors++; $display("FAIL wb_select_alu got=%h exp=%h", d_wb_data, 64'h0000_0000_DEAD_BEEF); end
    checks++;
    if (d_wb_we !== 1'b1) begin errors++; $display("FAIL wb_we_rd5 got=%b exp=1", d_wb_we); end
    checks++;
    if (n_rs1 !== 64'd0) begin errors++; $display("FAIL nobyp_before_edge got=%h exp=0", n_rs1); end
    @(posedge clk); #1;
    RegWrite_in = 1'b0; #1;
    checks++;
    if (d_rs1 !== 64'h0000_0000_DEAD_BEEF || n_rs1 !== 64'h0000_0000_DEAD_BEEF) begin
      errors++; $display("FAIL write_x5 got=%h/%h exp=%h", d_rs1, n_rs1, 64'h0000_0000_DEAD_BEEF);
    end
    checks++;
    if (d_rs2 !== 64'd0 || n_rs2 !== 64'd0) begin errors++; $display("FAIL x6_untouched got=%h/%h exp=0", d_rs2, n_rs2); end
  endtask

  task automatic test_bypass;
    @(negedge clk);
    RegWrite_in = 1'b1; MemtoReg_in = 1'b1; rd_in = 5'd7;
    mem_data_in = 64'hFFFF_FFFF_FFFF_FFFF; alu_result_in = 64'h0000_0000_0000_0042;
    rs1_addr = 5'd7; rs2_addr = 5'd7; #1;
    checks++;
    if (d_wb_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL wb_select_mem got=%h exp=all-ones", d_wb_data); end
    checks++;
    if (d_rs1 !== 64'hFFFF_FFFF_FFFF_FFFF || d_rs2 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL bypass_x7 got=%h/%h exp=all-ones", d_rs1, d_rs2);
    end
    checks++;
    if (n_rs1 !== 64'd0 || n_rs2 !== 64'd0) begin errors++; $display("FAIL nobypass_x7_old got=%h/%h exp=0", n_rs1, n_rs2); end
    @(posedge clk); #1;
    RegWrite_in = 1'b0; #1;
    checks++;
    if (n_rs1 !== 64'hFFFF_FFFF_FFFF_FFFF || n_rs2 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL nobypass_x7_after got=%h/%h exp=all-ones", n_rs1, n_rs2);
    end
  endtask

  task automatic test_x0;
    @(negedge clk);
    RegWrite_in = 1'b1; MemtoReg_in = 1'b0; rd_in = 5'd0;
    alu_result_in = 64'h1234; mem_data_in = 64'h9999;
    rs1_addr = 5'd0; rs2_addr = 5'd0; #1;
    checks++;
    if (d_wb_we !== 1'b0) begin errors++; $display("FAIL x0_wb_we got=%b exp=0", d_wb_we); end
    checks++;
    if (d_wb_data !== 64'h1234) begin errors++; $display("FAIL x0_wb_data got=%h exp=1234", d_wb_data); end
    checks++;
    if (d_rs1 !== 64'd0 || d_rs2 !== 64'd0) begin errors++; $display("FAIL x0_no_bypass got=%h/%h exp=0", d_rs1, d_rs2); end
    @(posedge clk); #1;
    RegWrite_in = 1'b0; #1;
    checks++;
    if (d_rs1 !== 64'd0 || n_rs1 !== 64'd0) begin errors++; $display("FAIL x0_after_write got=%h/%h exp=0", d_rs1, n_rs1); end
`ifdef WB_RETIRE_COUNT_EN
    checks++;
    if (d_cnt !== 64'd2) begin errors++; $display("FAIL x0_count got=%h exp=2", d_cnt); end
`endif
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    RegWrite_in = 1'b1; MemtoReg_in = 1'b1; rd_in = 5'd31;
    mem_data_in = 64'hA5A5; alu_result_in = 64'h0;
    rs1_addr = 5'd31; rs2_addr = 5'd31; #1;
    checks++;
    if (d_rs1 !== 64'hA5A5 || d_rs2 !== 64'hA5A5) begin errors++; $display("FAIL bypass_x31 got=%h/%h exp=a5a5", d_rs1, d_rs2); end
    checks++;
    if (n_rs1 !== 64'd0) begin errors++; $display("FAIL nobypass_x31 got=%h exp=0", n_rs1); end
    @(negedge clk);
    MemtoReg_in = 1'b0; rd_in = 5'd1; alu_result_in = 64'h5A5A; mem_data_in = 64'h0;
    rs1_addr = 5'd1; rs2_addr = 5'd31; #1;
    checks++;
    if (d_rs1 !== 64'h5A5A || d_rs2 !== 64'hA5A5) begin errors++; $display("FAIL b2b_dut got=%h/%h exp=5a5a/a5a5", d_rs1, d_rs2); end
    checks++;
    if (n_rs1 !== 64'd0 || n_rs2 !== 64'hA5A5) begin errors++; $display("FAIL b2b_nobyp got=%h/%h exp=0/a5a5", n_rs1, n_rs2); end
    @(posedge clk); #1;
    RegWrite_in = 1'b0; #1;
    checks++;
    if (n_rs1 !== 64'h5A5A) begin errors++; $display("FAIL b2b_x1_stored got=%h exp=5a5a", n_rs1); end
`ifdef WB_RETIRE_COUNT_EN
    checks++;
    if (d_cnt !== 64'd4) begin errors++; $display("FAIL b2b_count got=%h exp=4", d_cnt); end
`endif
  endtask

  task automatic test_async_reset;
    // Pending write to x1 while reset arrives between edges.
    RegWrite_in = 1'b1; MemtoReg_in = 1'b0; rd_in = 5'd1;
    alu_result_in = 64'h77; mem_data_in = 64'h0;
    rs1_addr = 5'd1; rs2_addr = 5'd31;
    #2 reset = 1'b1; #1;
    checks++;
    if (n_rs1 !== 64'd0 || n_rs2 !== 64'd0 || d_rs2 !== 64'd0) begin
      errors++; $display("FAIL async_reset_clear got=%h/%h/%h exp=0", n_rs1, n_rs2, d_rs2);
    end
    checks++;
    if (d_rs1 !== 64'h77) begin errors++; $display("FAIL reset_bypass got=%h exp=77", d_rs1); end
`ifdef WB_RETIRE_COUNT_EN
    checks++;
    if (d_cnt !== 64'd0) begin errors++; $display("FAIL reset_count_clear got=%h exp=0", d_cnt); end
`endif
    @(posedge clk); #1;
    RegWrite_in = 1'b0; #1;
    checks++;
    if (d_rs1 !== 64'd0 || n_rs1 !== 64'd0) begin errors++; $display("FAIL no_write_in_reset got=%h/%h exp=0", d_rs1, n_rs1); end
    @(negedge clk); reset = 1'b0;
    write_reg(5'd1, 64'd3);
    rs1_addr = 5'd1; #1;
    checks++;
    if (d_rs1 !== 64'd3 || n_rs1 !== 64'd3) begin errors++; $display("FAIL post_reset_write got=%h/%h exp=3", d_rs1, n_rs1); end
`ifdef WB_RETIRE_COUNT_EN
    checks++;
    if (d_cnt !== 64'd1) begin errors++; $display("FAIL post_reset_count got=%h exp=1", d_cnt); end
`endif
  endtask

`ifdef WB_RETIRE_COUNT_EN
  task automatic test_wrap;
    logic [63:0] exp_cnt [3];
    exp_cnt[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    exp_cnt[1] = 64'h0;
    exp_cnt[2] = 64'h1;
    @(negedge clk);
    force dut.r_retire_count = 64'hFFFF_FFFF_FFFF_FFFE;
    #1 release dut.r_retire_count;
    for (int i = 0; i < 3; i++) begin
      write_reg(5'd2, 64'(i + 10));
      #1;
      checks++;
      if (d_cnt !== exp_cnt[i]) begin errors++; $display("FAIL count_wrap step=%0d got=%h exp=%h", i, d_cnt, exp_cnt[i]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_bypass();
    test_x0();
    test_back_to_back();
    test_async_reset();
`ifdef WB_RETIRE_COUNT_EN
    test_wrap();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_wb_regfile
